// File: rtl/panzoom_pkg.sv
// panzoom_pkg: shared state type, defaults and helpers for the pan/zoom capture path
`ifndef PZ_CH
`define PZ_CH(bus, ch, dw) bus[(ch)*(dw) +: (dw)]
`endif

package panzoom_pkg;

    localparam int PZ_DW        = 16;
    localparam int PZ_NCHAN     = 2;
    localparam int PZ_MEMAW     = 10;
    localparam int PZ_DRAIN_CYC = 4;

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} pz_state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/panzoom_capture_dpram.sv
// panzoom_capture_dpram: simple dual-port RAM, one write port, one read-first registered read port
module panzoom_capture_dpram #(
    parameter int W  = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/panzoom_capture.sv
// panzoom_capture: capture buffer for decimated pan/zoom words with arm/capture/drain/done control and host readout
module panzoom_capture
    import panzoom_pkg::*;
#(
    parameter int DW        = PZ_DW,
    parameter int NCHAN     = PZ_NCHAN,
    parameter int MEMAW     = PZ_MEMAW,
    parameter int DRAIN_CYC = PZ_DRAIN_CYC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic [NCHAN*DW-1:0]   din,
    input  logic                  din_valid,
    input  logic [MEMAW-1:0]      waddr,
    input  logic                  stopped,
    input  logic                  rd_en,
    input  logic [MEMAW-1:0]      rd_addr,
    output logic [NCHAN*DW-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  done_irq,
    output logic [MEMAW:0]        wcount,
    output logic                  addr_err
);

    localparam int W     = NCHAN * DW;
    localparam int MW    = MEMAW + 1;
    localparam int DEPTH = depth_of(MEMAW);
    localparam int DCW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [MEMAW:0] FULL_W  = MW'(DEPTH);
    localparam logic [MEMAW:0] LAST_W  = MW'(DEPTH - 1);
    localparam logic [DCW-1:0] DLAST   = DCW'(DRAIN_CYC - 1);

    pz_state_t      state;
    logic           stopped_q;
    logic           rd_en_q;
    logic [DCW-1:0] dcnt;
    logic [W-1:0]   ram_q;
    logic           rise;
    logic           wr_ok;
    logic           arm_ok;

    assign rise   = stopped & ~stopped_q;
    assign wr_ok  = (state == CAPTURE || state == DRAIN) && din_valid && (wcount != FULL_W);
    assign arm_ok = arm && (state == IDLE || state == DONE);

    panzoom_capture_dpram #(.W(W), .AW(MEMAW)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (waddr),
        .wdata (din),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // arm takes priority over any coincident strobe, so a DONE-state write is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stopped_q <= 1'b1;
            dcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_irq  <= 1'b0;
            wcount    <= '0;
            addr_err  <= 1'b0;
        end else begin
            stopped_q <= stopped;
            done_irq  <= 1'b0;
            if (arm_ok) begin
                state    <= ARMED;
                busy     <= 1'b1;
                done     <= 1'b0;
                wcount   <= '0;
                addr_err <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wcount <= wcount + 1'b1;
                    if (waddr != wcount[MEMAW-1:0]) addr_err <= 1'b1;
                end
                case (state)
                    ARMED: if (!stopped) state <= CAPTURE;
                    CAPTURE: if (rise || (wr_ok && wcount == LAST_W)) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end
                    DRAIN: if (dcnt == DLAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        done_irq <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // second read stage: RAM output register feeds the held host data register
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_en_q  <= rd_en;
            rd_valid <= rd_en_q;
            if (rd_en_q) rd_data <= ram_q;
        end
    end

endmodule

// File: tb/tb_panzoom_capture.sv
// tb_panzoom_capture: directed scoreboard bench for panzoom_capture (MEMAW=4, depth 16)
module tb_panzoom_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic [3:0]  waddr = '0;
    logic        stopped = 1'b1;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        done_irq;
    logic [4:0]  wcount;
    logic        addr_err;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int irq_cnt = 0;
    logic [63:0] exp_q [$];

    panzoom_capture #(.MEMAW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .din       (din),
        .din_valid (din_valid),
        .waddr     (waddr),
        .stopped   (stopped),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .done_irq  (done_irq),
        .wcount    (wcount),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every rd_valid pops the next expected word and its expected arrival cycle
    always @(negedge clk) begin
        logic [63:0] e;
        if (done_irq) irq_cnt <= irq_cnt + 1;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e[63:32]);
                check("rd_latency", cyc, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] p1(input int i);
        logic [15:0] a = 16'(i);
        logic [15:0] b = 16'(-i);
        return {a, b};
    endfunction

    function automatic logic [31:0] p2(input int i);
        return {16'h2000 + 16'(i), 16'h3000 + 16'(i)};
    endfunction

    function automatic logic [31:0] p3(input int i);
        return {16'h4000 + 16'(i), 16'h5000 + 16'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        waddr = a;
        din = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        rd_addr = a;
        rd_en = 1'b1;
        exp_q.push_back({e, 32'(cyc + 2)});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        int n;
        int irq_base;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_irq", done_irq, 0);
        check("rst_wcount", wcount, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);

        // 1: basic capture, drain timing, readout
        do_arm();
        check("t1_busy_armed", busy, 1);
        stopped = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) wr(4'(i), p1(i));
        stopped = 1'b1;
        tick();
        n = 0;
        while (!done_irq && n < 20) begin
            tick();
            n++;
        end
        check("t1_irq_delay", n, 4);
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_wcount", wcount, 8);
        check("t1_addr_err", addr_err, 0);
        tick();
        check("t1_irq_pulse", done_irq, 0);
        for (int i = 0; i < 8; i++) rd(4'(i), p1(i));
        repeat (4) tick();
        check("t1_rd_hold", rd_data, p1(7));
        check("t1_rd_idle", rd_valid, 0);

        // 2: strobe coincident with the edge and one cycle after are kept; late strobe dropped
        do_arm();
        stopped = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) wr(4'(i), p2(i));
        stopped = 1'b1;
        wr(4'd7, p2(7));
        wr(4'd8, p2(8));
        repeat (3) tick();
        check("t2_irq", done_irq, 1);
        wr(4'd9, p2(9));
        check("t2_wcount", wcount, 9);
        check("t2_addr_err", addr_err, 0);
        rd(4'd7, p2(7));
        rd(4'd8, p2(8));
        repeat (3) tick();

        // 3: arm beats a coincident strobe in DONE; saturation at depth ends the capture
        stopped = 1'b0;
        arm = 1'b1;
        waddr = 4'd0;
        din = 32'hDEADBEEF;
        din_valid = 1'b1;
        tick();
        arm = 1'b0;
        din_valid = 1'b0;
        check("t3_arm_busy", busy, 1);
        check("t3_arm_wcount", wcount, 0);
        rd(4'd0, p2(0));
        for (int i = 0; i < 20; i++) begin
            wr(4'(i), p3(i));
            if (i == 18) check("t3_irq_early", done_irq, 0);
        end
        check("t3_irq", done_irq, 1);
        check("t3_done", done, 1);
        check("t3_wcount", wcount, 16);
        check("t3_addr_err", addr_err, 0);
        for (int i = 0; i < 16; i++) rd(4'(i), p3(i));
        repeat (3) tick();

        // 4: non-sequential address raises a sticky error cleared by re-arm
        do_arm();
        tick();
        wr(4'd0, 32'h1);
        wr(4'd1, 32'h2);
        check("t4_err_before", addr_err, 0);
        wr(4'd3, 32'h3);
        check("t4_err_set", addr_err, 1);
        wr(4'd3, 32'h4);
        check("t4_err_sticky", addr_err, 1);
        stopped = 1'b1;
        repeat (5) tick();
        check("t4_done", done, 1);
        check("t4_err_done", addr_err, 1);
        do_arm();
        check("t4_err_clear", addr_err, 0);
        check("t4_wcount_clear", wcount, 0);
        check("t4_done_clear", done, 0);

        // 5: reset mid-capture aborts without an interrupt; strobes ignored afterwards
        stopped = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) wr(4'(i), 32'h77);
        check("t5_wcount", wcount, 5);
        irq_base = irq_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_wcount_rst", wcount, 0);
        check("t5_done", done, 0);
        for (int i = 0; i < 3; i++) wr(4'(i), 32'h88);
        check("t5_ignored", wcount, 0);
        stopped = 1'b1;
        repeat (8) tick();
        check("t5_no_irq", irq_cnt, irq_base);
        check("t5_busy_idle", busy, 0);

        // 6: same-address read and write in one cycle returns the old word
        do_arm();
        stopped = 1'b0;
        tick();
        wr(4'd0, 32'h0);
        wr(4'd1, 32'h1);
        wr(4'd2, 32'h0000AAAA);
        stopped = 1'b1;
        repeat (6) tick();
        do_arm();
        stopped = 1'b0;
        tick();
        wr(4'd0, 32'h0);
        wr(4'd1, 32'h1);
        waddr = 4'd2;
        din = 32'h00005555;
        din_valid = 1'b1;
        rd(4'd2, 32'h0000AAAA);
        din_valid = 1'b0;
        rd(4'd2, 32'h00005555);
        repeat (5) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
